// File: rtl/img_tap_scheduler_if.sv
// Request, ROM and tap-set bundle for the 5-point neighbourhood scheduler.
// The scheduler uses the slave modport. The requester, ROM and consumer side uses the master modport.
interface img_tap_scheduler_if #(
   parameter int COORD_W = 7,
   parameter int ADDR_W  = 14,
   parameter int PIX_W   = 24
);
   logic               req_valid;
   logic               req_ready;
   logic [COORD_W-1:0] req_x;
   logic [COORD_W-1:0] req_y;
   logic               rom_en;
   logic [ADDR_W-1:0]  rom_addr;
   logic [PIX_W-1:0]   rom_data;
   logic               out_valid;
   logic               out_ready;
   logic               out_err;
   logic [PIX_W-1:0]   tap_c;
   logic [PIX_W-1:0]   tap_n;
   logic [PIX_W-1:0]   tap_w;
   logic [PIX_W-1:0]   tap_e;
   logic [PIX_W-1:0]   tap_s;
   logic               busy;

   modport slave (
      input  req_valid, req_x, req_y, rom_data, out_ready,
      output req_ready, rom_en, rom_addr, out_valid, out_err,
             tap_c, tap_n, tap_w, tap_e, tap_s, busy
   );

   modport master (
      output req_valid, req_x, req_y, rom_data, out_ready,
      input  req_ready, rom_en, rom_addr, out_valid, out_err,
             tap_c, tap_n, tap_w, tap_e, tap_s, busy
   );
endinterface

// File: rtl/img_tap_scheduler.sv
// Time-shares one single-port image ROM to fetch the centre, north, west, east and
// south pixels of a requested coordinate. Neighbours that fall off the image edge
// are replaced by the centre pixel, so the address is clamped to the centre.
module img_tap_scheduler #(
   parameter int IMG_W   = 100,
   parameter int IMG_H   = 100,
   parameter int COORD_W = 7,
   parameter int ADDR_W  = 14,
   parameter int PIX_W   = 24
) (
   input  logic                clk,
   input  logic                reset,
   img_tap_scheduler_if.slave  bus
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [ADDR_W:0]  IMG_W_A = (ADDR_W+1)'(IMG_W);
   localparam logic [ADDR_W:0]  ONE_A   = (ADDR_W+1)'(1);
   localparam logic [COORD_W:0] IMG_W_C = (COORD_W+1)'(IMG_W);
   localparam logic [COORD_W:0] IMG_H_C = (COORD_W+1)'(IMG_H);
   localparam logic [COORD_W-1:0] X_MAX = COORD_W'(IMG_W-1);
   localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(IMG_H-1);
   localparam logic [COORD_W-1:0] ZERO_C = {COORD_W{1'b0}};

   // Address of tap k (0=C,1=N,2=W,3=E,4=S), edge-clamped, computed one bit wider than the ROM address.
   function automatic logic [ADDR_W:0] tap_addr(input logic [COORD_W-1:0] x,
                                                input logic [COORD_W-1:0] y,
                                                input logic [2:0] k);
      logic [ADDR_W:0] c;
      logic [ADDR_W:0] a;
      c = IMG_W_A * {{(ADDR_W+1-COORD_W){1'b0}}, y} + {{(ADDR_W+1-COORD_W){1'b0}}, x};
      case (k)
         3'd0:    a = c;
         3'd1:    a = (y == ZERO_C) ? c : c - IMG_W_A;
         3'd2:    a = (x == ZERO_C) ? c : c - ONE_A;
         3'd3:    a = (x == X_MAX)  ? c : c + ONE_A;
         3'd4:    a = (y == Y_MAX)  ? c : c + IMG_W_A;
         default: a = c;
      endcase
      return a;
   endfunction

   logic [1:0]         state_q, state_d;
   logic [2:0]         cnt_q, cnt_d;
   logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
   logic               rom_en_q, rom_en_d;
   logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
   logic               out_valid_q, out_valid_d;
   logic               out_err_q, out_err_d;
   logic               req_ready_q, busy_q;
   logic [PIX_W-1:0]   tap_c_q, tap_c_d, tap_n_q, tap_n_d, tap_w_q, tap_w_d;
   logic [PIX_W-1:0]   tap_e_q, tap_e_d, tap_s_q, tap_s_d;

   logic [COORD_W-1:0] addr_x_s, addr_y_s;
   logic [2:0]         addr_k_s;
   logic [ADDR_W:0]    next_addr_s;
   logic               addr_msb_unused_s;
   logic               in_range_s;

   // Address source: live request at accept (centre tap), latched coordinates afterwards.
   always_comb begin
      addr_x_s = x_q;
      addr_y_s = y_q;
      addr_k_s = cnt_q;
      if (state_q == S_IDLE) begin
         addr_x_s = bus.req_x;
         addr_y_s = bus.req_y;
         addr_k_s = 3'd0;
      end else begin
         addr_k_s = cnt_q;
      end
   end

   assign next_addr_s       = tap_addr(addr_x_s, addr_y_s, addr_k_s);
   assign addr_msb_unused_s = next_addr_s[ADDR_W];
   assign in_range_s        = ({1'b0, bus.req_x} < IMG_W_C) && ({1'b0, bus.req_y} < IMG_H_C);

   // Sequencing: cnt_q holds the index n of the edge e_n about to occur after accept.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      x_d         = x_q;
      y_d         = y_q;
      rom_en_d    = rom_en_q;
      rom_addr_d  = rom_addr_q;
      out_valid_d = out_valid_q;
      out_err_d   = out_err_q;
      tap_c_d     = tap_c_q;
      tap_n_d     = tap_n_q;
      tap_w_d     = tap_w_q;
      tap_e_d     = tap_e_q;
      tap_s_d     = tap_s_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               x_d = bus.req_x;
               y_d = bus.req_y;
               if (in_range_s) begin
                  rom_addr_d = next_addr_s[ADDR_W-1:0];
                  rom_en_d   = 1'b1;
                  cnt_d      = 3'd1;
                  state_d    = S_ISSUE;
               end else begin
                  out_err_d   = 1'b1;
                  out_valid_d = 1'b1;
                  tap_c_d     = {PIX_W{1'b0}};
                  tap_n_d     = {PIX_W{1'b0}};
                  tap_w_d     = {PIX_W{1'b0}};
                  tap_e_d     = {PIX_W{1'b0}};
                  tap_s_d     = {PIX_W{1'b0}};
                  state_d     = S_DONE;
               end
            end else begin
               rom_en_d = 1'b0;
            end
         end
         S_ISSUE: begin
            rom_addr_d = next_addr_s[ADDR_W-1:0];
            rom_en_d   = 1'b1;
            cnt_d      = cnt_q + 3'd1;
            if (cnt_q == 3'd4) begin
               state_d = S_DRAIN;
            end else begin
               state_d = S_ISSUE;
            end
         end
         S_DRAIN: begin
            rom_en_d = 1'b0;
            cnt_d    = cnt_q + 3'd1;
            if (cnt_q == 3'd6) begin
               out_valid_d = 1'b1;
               out_err_d   = 1'b0;
               state_d     = S_DONE;
            end else begin
               state_d = S_DRAIN;
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               out_err_d   = 1'b0;
               state_d     = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            rom_en_d    = 1'b0;
            out_valid_d = 1'b0;
            out_err_d   = 1'b0;
            state_d     = S_IDLE;
         end
      endcase

      // ROM data for the address registered at e_{n-2} is captured at e_n.
      if ((state_q == S_ISSUE) || (state_q == S_DRAIN)) begin
         case (cnt_q)
            3'd2:    tap_c_d = bus.rom_data;
            3'd3:    tap_n_d = bus.rom_data;
            3'd4:    tap_w_d = bus.rom_data;
            3'd5:    tap_e_d = bus.rom_data;
            3'd6:    tap_s_d = bus.rom_data;
            default: tap_c_d = tap_c_q;
         endcase
      end else begin
         cnt_d = cnt_d;
      end
   end

   // State and output registers with synchronous reset that aborts any fetch in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= 3'd0;
         x_q         <= {COORD_W{1'b0}};
         y_q         <= {COORD_W{1'b0}};
         rom_en_q    <= 1'b0;
         rom_addr_q  <= {ADDR_W{1'b0}};
         out_valid_q <= 1'b0;
         out_err_q   <= 1'b0;
         req_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         tap_c_q     <= {PIX_W{1'b0}};
         tap_n_q     <= {PIX_W{1'b0}};
         tap_w_q     <= {PIX_W{1'b0}};
         tap_e_q     <= {PIX_W{1'b0}};
         tap_s_q     <= {PIX_W{1'b0}};
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         x_q         <= x_d;
         y_q         <= y_d;
         rom_en_q    <= rom_en_d;
         rom_addr_q  <= rom_addr_d;
         out_valid_q <= out_valid_d;
         out_err_q   <= out_err_d;
         req_ready_q <= (state_d == S_IDLE);
         busy_q      <= (state_d != S_IDLE);
         tap_c_q     <= tap_c_d;
         tap_n_q     <= tap_n_d;
         tap_w_q     <= tap_w_d;
         tap_e_q     <= tap_e_d;
         tap_s_q     <= tap_s_d;
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.busy      = busy_q;
   assign bus.rom_en    = rom_en_q;
   assign bus.rom_addr  = rom_addr_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_err   = out_err_q;
   assign bus.tap_c     = tap_c_q;
   assign bus.tap_n     = tap_n_q;
   assign bus.tap_w     = tap_w_q;
   assign bus.tap_e     = tap_e_q;
   assign bus.tap_s     = tap_s_q;

endmodule

// File: tb/tb_img_tap_scheduler.sv
// Bench for img_tap_scheduler: directed corner requests plus random ones, checked
// against a coordinate-clamping neighbourhood model and a 1-cycle registered ROM.
module tb_img_tap_scheduler;
   localparam int IMG_W = 100;
   localparam int IMG_H = 100;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic [13:0] rom_log[$];

   img_tap_scheduler_if #(.COORD_W(7), .ADDR_W(14), .PIX_W(24)) bus();

   img_tap_scheduler #(.IMG_W(IMG_W), .IMG_H(IMG_H), .COORD_W(7), .ADDR_W(14), .PIX_W(24))
      dut (.clk(clk), .reset(reset), .bus(bus.slave));

   always #5 clk = ~clk;

   // ROM model: data is the zero-extended address, one registered cycle later; also logs reads.
   always @(posedge clk) begin
      if (bus.rom_en === 1'b1) begin
         bus.rom_data <= {10'd0, bus.rom_addr};
         rom_log.push_back(bus.rom_addr);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int pix(input int x, input int y);
      return IMG_W * y + x;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One request/response transaction; dly = cycles out_ready is held low after out_valid.
   task automatic run_req(input int x, input int y, input int dly);
      int et[5];
      bit err;
      int lat;
      err = (x >= IMG_W) || (y >= IMG_H);
      if (err) begin
         for (int k = 0; k < 5; k++) et[k] = 0;
      end else begin
         et[0] = pix(x, y);
         et[1] = pix(x, (y > 0) ? y - 1 : 0);
         et[2] = pix((x > 0) ? x - 1 : 0, y);
         et[3] = pix((x < IMG_W - 1) ? x + 1 : IMG_W - 1, y);
         et[4] = pix(x, (y < IMG_H - 1) ? y + 1 : IMG_H - 1);
      end
      chk("ready_before", bus.req_ready, 1);
      rom_log.delete();
      bus.req_valid = 1'b1;
      bus.req_x = 7'(x);
      bus.req_y = 7'(y);
      tick();
      bus.req_valid = 1'b0;
      bus.req_x = 7'($urandom_range(0, 127));
      bus.req_y = 7'($urandom_range(0, 127));
      chk("busy_after_accept", bus.busy, 1);
      chk("ready_after_accept", bus.req_ready, 0);
      lat = 0;
      while ((bus.out_valid !== 1'b1) && (lat < 20)) begin
         tick();
         lat++;
      end
      chk("latency", lat, err ? 0 : 6);
      chk("out_valid", bus.out_valid, 1);
      chk("out_err", bus.out_err, err ? 1 : 0);
      chk("tap_c", bus.tap_c, et[0]);
      chk("tap_n", bus.tap_n, et[1]);
      chk("tap_w", bus.tap_w, et[2]);
      chk("tap_e", bus.tap_e, et[3]);
      chk("tap_s", bus.tap_s, et[4]);
      for (int i = 0; i < dly; i++) begin
         bus.req_valid = 1'b1;
         bus.req_x = 7'($urandom_range(0, 99));
         bus.req_y = 7'($urandom_range(0, 99));
         tick();
         chk("hold_valid", bus.out_valid, 1);
         chk("hold_ready", bus.req_ready, 0);
         chk("hold_tap_c", bus.tap_c, et[0]);
         chk("hold_tap_s", bus.tap_s, et[4]);
         chk("hold_err", bus.out_err, err ? 1 : 0);
      end
      bus.req_valid = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("release_valid", bus.out_valid, 0);
      chk("release_err", bus.out_err, 0);
      chk("release_ready", bus.req_ready, 1);
      chk("release_busy", bus.busy, 0);
      chk("rom_count", rom_log.size(), err ? 0 : 5);
      if (!err) begin
         for (int k = 0; k < 5; k++) begin
            if (k < rom_log.size()) chk("rom_addr", {18'd0, rom_log[k]}, et[k]);
         end
      end
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_x     = 7'd0;
      bus.req_y     = 7'd0;
      bus.out_ready = 1'b0;
      bus.rom_data  = 24'd0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_ready", bus.req_ready, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_rom_en", bus.rom_en, 0);
      chk("rst_rom_addr", bus.rom_addr, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_err", bus.out_err, 0);
      chk("rst_tap_c", bus.tap_c, 0);
      chk("rst_tap_s", bus.tap_s, 0);

      run_req(50, 50, 0);
      run_req(0, 0, 1);
      run_req(99, 99, 2);
      run_req(100, 5, 3);
      run_req(10, 20, 10);
      run_req(99, 0, 0);
      run_req(0, 99, 0);
      run_req(5, 127, 1);

      // Reset in the middle of the fetch sequence.
      bus.req_valid = 1'b1;
      bus.req_x = 7'd20;
      bus.req_y = 7'd30;
      tick();
      bus.req_valid = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_rom_en", bus.rom_en, 0);
      chk("abort_out_valid", bus.out_valid, 0);
      chk("abort_ready", bus.req_ready, 1);
      chk("abort_busy", bus.busy, 0);
      run_req(1, 1, 0);

      for (int i = 0; i < 24; i++) begin
         run_req($urandom_range(0, 109), $urandom_range(0, 109), $urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
